// File: rtl/one_bit_full_sub_if.sv
// Signal bundle for the one-bit full subtractor: combinational cell inputs and outputs
// plus the bit-serial word path.
interface one_bit_full_sub_if;
    logic A;
    logic B;
    logic BorrowIn;
    logic in_valid;
    logic sow;
    logic Diff;
    logic BorrowOut;
    logic ser_diff;
    logic ser_valid;
    logic eow;
    logic word_borrow;

    modport master (
        output A, B, BorrowIn, in_valid, sow,
        input  Diff, BorrowOut, ser_diff, ser_valid, eow, word_borrow
    );

    modport slave (
        input  A, B, BorrowIn, in_valid, sow,
        output Diff, BorrowOut, ser_diff, ser_valid, eow, word_borrow
    );
endinterface

// File: rtl/one_bit_full_sub.sv
// One-bit full subtractor (A - B - BorrowIn) with a zero-latency combinational cell
// and a registered bit-serial path that chains the borrow LSB-first across WORD_LEN bits.
module one_bit_full_sub #(
    parameter int unsigned WORD_LEN = 8
) (
    input  logic             clk,
    input  logic             rst,
    one_bit_full_sub_if.slave bus
);

    localparam int unsigned CNT_W = $clog2(WORD_LEN) + 1;

    // Returns {borrow, diff} for a - b - bin.
    function automatic logic [1:0] full_sub(input logic a, input logic b, input logic bin);
        logic d;
        logic bo;
        d  = a ^ b ^ bin;
        bo = (~a & b) | (~a & bin) | (b & bin);
        return {bo, d};
    endfunction

    logic [1:0] cell_c;

    assign cell_c        = full_sub(bus.A, bus.B, bus.BorrowIn);
    assign bus.Diff      = cell_c[0];
    assign bus.BorrowOut = cell_c[1];

    logic             ser_diff_q,    ser_diff_d;
    logic             ser_valid_q,   ser_valid_d;
    logic             eow_q,         eow_d;
    logic             word_borrow_q, word_borrow_d;
    logic             borrow_q,      borrow_d;
    logic [CNT_W-1:0] bit_cnt_q,     bit_cnt_d;

    logic             eb_c;
    logic [1:0]       ser_c;
    logic [CNT_W-1:0] cnt_next_c;

    // Next-state for the serial path; a sow bit restarts the word from BorrowIn.
    always_comb begin
        ser_diff_d    = ser_diff_q;
        ser_valid_d   = 1'b0;
        eow_d         = 1'b0;
        word_borrow_d = word_borrow_q;
        borrow_d      = borrow_q;
        bit_cnt_d     = bit_cnt_q;

        eb_c       = bus.sow ? bus.BorrowIn : borrow_q;
        ser_c      = full_sub(bus.A, bus.B, eb_c);
        cnt_next_c = bus.sow ? CNT_W'(1) : CNT_W'(bit_cnt_q + CNT_W'(1));

        if (bus.in_valid) begin
            ser_diff_d  = ser_c[0];
            ser_valid_d = 1'b1;
            borrow_d    = ser_c[1];
            bit_cnt_d   = cnt_next_c;
            if (cnt_next_c == CNT_W'(WORD_LEN)) begin
                eow_d         = 1'b1;
                word_borrow_d = ser_c[1];
                bit_cnt_d     = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ser_diff_q    <= 1'b0;
            ser_valid_q   <= 1'b0;
            eow_q         <= 1'b0;
            word_borrow_q <= 1'b0;
            borrow_q      <= 1'b0;
            bit_cnt_q     <= '0;
        end else begin
            ser_diff_q    <= ser_diff_d;
            ser_valid_q   <= ser_valid_d;
            eow_q         <= eow_d;
            word_borrow_q <= word_borrow_d;
            borrow_q      <= borrow_d;
            bit_cnt_q     <= bit_cnt_d;
        end
    end

    assign bus.ser_diff    = ser_diff_q;
    assign bus.ser_valid   = ser_valid_q;
    assign bus.eow         = eow_q;
    assign bus.word_borrow = word_borrow_q;

endmodule

// File: tb/tb_one_bit_full_sub.sv
// Directed self-checking bench for one_bit_full_sub: combinational truth table and
// serial word subtraction with borrow-in, gaps, sow abort, async reset and sow-less start.
module tb_one_bit_full_sub;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    one_bit_full_sub_if bus ();

    one_bit_full_sub #(.WORD_LEN(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Apply one cycle of inputs after the falling edge; return 1 time unit after the rising edge.
    task automatic drive_bit(input logic a, input logic b, input logic bin,
                             input logic s, input logic v);
        @(negedge clk);
        bus.A        = a;
        bus.B        = b;
        bus.BorrowIn = bin;
        bus.sow      = s;
        bus.in_valid = v;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst          = 1'b1;
        bus.A        = 1'b0;
        bus.B        = 1'b0;
        bus.BorrowIn = 1'b0;
        bus.sow      = 1'b0;
        bus.in_valid = 1'b0;
        #3;
        total++;
        if ({bus.ser_diff, bus.ser_valid, bus.eow, bus.word_borrow} !== 4'b0000) begin
            bad++;
            $display("FAIL reset_state got=%b want=0000",
                     {bus.ser_diff, bus.ser_valid, bus.eow, bus.word_borrow});
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_comb();
        logic [7:0] exp_d;
        logic [7:0] exp_b;
        exp_d = 8'b1001_0110;
        exp_b = 8'b1000_1110;
        bus.in_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            {bus.A, bus.B, bus.BorrowIn} = 3'(i);
            #5;
            total++;
            if (bus.Diff !== exp_d[i]) begin
                bad++;
                $display("FAIL comb_diff abbin=%b got=%b want=%b", 3'(i), bus.Diff, exp_d[i]);
            end
            total++;
            if (bus.BorrowOut !== exp_b[i]) begin
                bad++;
                $display("FAIL comb_borrow abbin=%b got=%b want=%b", 3'(i), bus.BorrowOut, exp_b[i]);
            end
        end
    endtask

    task automatic test_sub_no_borrow();
        logic [7:0] a = 8'h35;
        logic [7:0] b = 8'h12;
        logic [7:0] res = '0;
        for (int i = 0; i < 8; i++) begin
            drive_bit(a[i], b[i], 1'b0, i == 0, 1'b1);
            res[i] = bus.ser_diff;
            total++;
            if (bus.ser_valid !== 1'b1 || bus.eow !== (i == 7)) begin
                bad++;
                $display("FAIL nb_handshake bit=%0d valid=%b eow=%b want valid=1 eow=%b",
                         i, bus.ser_valid, bus.eow, i == 7);
            end
        end
        total++;
        if (res !== 8'h23) begin
            bad++;
            $display("FAIL nb_result got=%h want=23", res);
        end
        total++;
        if (bus.word_borrow !== 1'b0) begin
            bad++;
            $display("FAIL nb_word_borrow got=%b want=0", bus.word_borrow);
        end
        drive_bit(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        total++;
        if ({bus.ser_valid, bus.eow} !== 2'b00) begin
            bad++;
            $display("FAIL nb_idle valid_eow got=%b want=00", {bus.ser_valid, bus.eow});
        end
    endtask

    task automatic test_borrow_in();
        logic [7:0] a = 8'h35;
        logic [7:0] b = 8'h12;
        logic [7:0] res = '0;
        // BorrowIn held high throughout: only the sow bit may use it.
        for (int i = 0; i < 8; i++) begin
            drive_bit(a[i], b[i], 1'b1, i == 0, 1'b1);
            res[i] = bus.ser_diff;
        end
        total++;
        if (res !== 8'h22 || bus.eow !== 1'b1 || bus.word_borrow !== 1'b0) begin
            bad++;
            $display("FAIL bin_result got=%h eow=%b wb=%b want=22 eow=1 wb=0",
                     res, bus.eow, bus.word_borrow);
        end
    endtask

    task automatic test_sub_borrow();
        logic [7:0] a = 8'h12;
        logic [7:0] b = 8'h35;
        logic [7:0] res = '0;
        for (int i = 0; i < 8; i++) begin
            drive_bit(a[i], b[i], 1'b0, i == 0, 1'b1);
            res[i] = bus.ser_diff;
        end
        total++;
        if (res !== 8'hDD) begin
            bad++;
            $display("FAIL b_result got=%h want=dd", res);
        end
        total++;
        if (bus.word_borrow !== 1'b1 || bus.eow !== 1'b1) begin
            bad++;
            $display("FAIL b_word_borrow wb=%b eow=%b want wb=1 eow=1", bus.word_borrow, bus.eow);
        end
        drive_bit(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        total++;
        if (bus.word_borrow !== 1'b1) begin
            bad++;
            $display("FAIL b_wb_hold got=%b want=1", bus.word_borrow);
        end
    endtask

    task automatic test_sow_abort();
        logic [7:0] a1 = 8'h12;
        logic [7:0] b1 = 8'h35;
        logic [7:0] a2 = 8'h35;
        logic [7:0] b2 = 8'h12;
        logic [7:0] res = '0;
        for (int i = 0; i < 4; i++) begin
            drive_bit(a1[i], b1[i], 1'b0, i == 0, 1'b1);
            total++;
            if (bus.eow !== 1'b0 || bus.word_borrow !== 1'b1) begin
                bad++;
                $display("FAIL abort_partial bit=%0d eow=%b wb=%b want eow=0 wb=1",
                         i, bus.eow, bus.word_borrow);
            end
        end
        for (int i = 0; i < 8; i++) begin
            drive_bit(a2[i], b2[i], 1'b0, i == 0, 1'b1);
            res[i] = bus.ser_diff;
            total++;
            if (bus.eow !== (i == 7)) begin
                bad++;
                $display("FAIL abort_new_eow bit=%0d got=%b want=%b", i, bus.eow, i == 7);
            end
        end
        total++;
        if (res !== 8'h23 || bus.word_borrow !== 1'b0) begin
            bad++;
            $display("FAIL abort_new_result got=%h wb=%b want=23 wb=0", res, bus.word_borrow);
        end
    endtask

    task automatic test_gaps();
        logic [7:0] a = 8'h12;
        logic [7:0] b = 8'h35;
        logic [7:0] res = '0;
        logic       held;
        for (int i = 0; i < 8; i++) begin
            drive_bit(a[i], b[i], 1'b0, i == 0, 1'b1);
            res[i] = bus.ser_diff;
            if (i == 1 || i == 4) begin
                held = bus.ser_diff;
                drive_bit(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
                total++;
                if (bus.ser_valid !== 1'b0 || bus.eow !== 1'b0 || bus.ser_diff !== held) begin
                    bad++;
                    $display("FAIL gap_idle bit=%0d valid=%b eow=%b diff=%b want valid=0 eow=0 diff=%b",
                             i, bus.ser_valid, bus.eow, bus.ser_diff, held);
                end
            end
        end
        total++;
        if (res !== 8'hDD || bus.word_borrow !== 1'b1 || bus.eow !== 1'b1) begin
            bad++;
            $display("FAIL gap_result got=%h wb=%b eow=%b want=dd wb=1 eow=1",
                     res, bus.word_borrow, bus.eow);
        end
    endtask

    task automatic test_async_reset();
        logic [7:0] a = 8'h35;
        logic [7:0] b = 8'h12;
        for (int i = 0; i < 3; i++) begin
            drive_bit(a[i], b[i], 1'b0, i == 0, 1'b1);
        end
        @(negedge clk);
        #2;
        bus.A        = 1'b1;
        bus.B        = 1'b0;
        bus.BorrowIn = 1'b0;
        rst          = 1'b1;
        #1;
        total++;
        if ({bus.ser_diff, bus.ser_valid, bus.eow, bus.word_borrow} !== 4'b0000) begin
            bad++;
            $display("FAIL async_reset got=%b want=0000",
                     {bus.ser_diff, bus.ser_valid, bus.eow, bus.word_borrow});
        end
        total++;
        if ({bus.Diff, bus.BorrowOut} !== 2'b10) begin
            bad++;
            $display("FAIL async_reset_comb got=%b want=10", {bus.Diff, bus.BorrowOut});
        end
        @(negedge clk);
        rst          = 1'b0;
        bus.in_valid = 1'b0;
    endtask

    task automatic test_no_sow_start();
        logic [7:0] a = 8'h35;
        logic [7:0] b = 8'h12;
        logic [7:0] res = '0;
        // Fresh from reset: count and borrow start at zero without sow.
        for (int i = 0; i < 8; i++) begin
            drive_bit(a[i], b[i], 1'b1, 1'b0, 1'b1);
            res[i] = bus.ser_diff;
            total++;
            if (bus.eow !== (i == 7)) begin
                bad++;
                $display("FAIL nosow_eow bit=%0d got=%b want=%b", i, bus.eow, i == 7);
            end
        end
        total++;
        if (res !== 8'h23 || bus.word_borrow !== 1'b0) begin
            bad++;
            $display("FAIL nosow_result got=%h wb=%b want=23 wb=0", res, bus.word_borrow);
        end
    endtask

    initial begin
        test_reset();
        test_comb();
        test_sub_no_borrow();
        test_borrow_in();
        test_sub_borrow();
        test_sow_abort();
        test_gaps();
        test_async_reset();
        test_no_sow_start();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/one_bit_full_sub.md
Name: one_bit_full_sub

Overview:
- 1-bit full subtractor computing A − B − BorrowIn.
- Primary outputs Diff/BorrowOut are purely combinational.
- A registered, bit-serial companion path chains the borrow across cycles, so the block can subtract WORD_LEN-bit operands LSB-first.
- Leaf arithmetic cell in the datapath library; used standalone or as a serial subtractor.

Parameters:
- WORD_LEN, 8, bits per serial word; legal range 1..64; sets bit-counter width clog2(WORD_LEN)+1.

Ports:
- clk  input  1  rising-edge clock for all registers.
- rst  input  1  asynchronous, active-high reset.
- A  input  1  minuend bit.
- B  input  1  subtrahend bit.
- BorrowIn  input  1  borrow into the combinational cell; also the first-bit borrow in serial mode.
- in_valid  input  1  qualifies A/B/sow for the serial path.
- sow  input  1  start of word; first (LSB) bit of a serial word, sampled with in_valid.
- Diff  output  1  combinational difference bit.
- BorrowOut  output  1  combinational borrow out.
- ser_diff  output  1  registered serial difference bit.
- ser_valid  output  1  registered; ser_diff is valid.
- eow  output  1  registered; pulses with the last bit of a word.
- word_borrow  output  1  registered; final borrow of the completed word, held until the next eow.

Behaviour:
- Combinational cell, independent of clk/rst, zero latency:
  - Diff = A xor B xor BorrowIn.
  - BorrowOut = (~A & B) | (~A & BorrowIn) | (B & BorrowIn).
  - Truth table, ABBin → Diff,BorrowOut: 000→0,0; 001→1,1; 010→1,1; 011→0,1; 100→1,0; 101→0,0; 110→0,0; 111→1,1.
  - No X propagation beyond inputs; outputs settle within the same delta/cycle as the inputs.
- Serial path, all registers reset asynchronously on rst=1:
  - On reset, ser_diff=0, ser_valid=0, eow=0, word_borrow=0, borrow_q=0, bit_cnt=0.
- Effective borrow: eb = (sow ? BorrowIn : borrow_q). The same full-subtract equations are evaluated on A, B, eb.
- On a clk edge with in_valid=1:
  - ser_diff ← diff(A,B,eb); ser_valid ← 1; borrow_q ← borrow(A,B,eb).
  - bit_cnt ← sow ? 1 : bit_cnt+1.
- Word end: when the new bit_cnt equals WORD_LEN, eow ← 1, word_borrow ← borrow(A,B,eb), and bit_cnt ← 0.
- On a clk edge with in_valid=0: ser_valid ← 0 and eow ← 0; borrow_q, bit_cnt, ser_diff and word_borrow hold.
- Latency: one cycle from in_valid to ser_valid.
- sow mid-word: aborts the current word without eow and restarts the count at 1. The previous word_borrow is unchanged.
- Bits arriving with bit_cnt=0 and sow=0 (no word started): processed using borrow_q; the count starts from 1.
- WORD_LEN=1: every valid bit asserts eow.
- rst asserted mid-word: everything clears immediately; the next word needs sow.

Test Plan:
- Sweep A,B,BorrowIn through all 8 combinations, 5 time units apart → Diff/BorrowOut match the truth table: 001→1,1; 011→0,1; 100→1,0; 111→1,1.
- Reset: assert rst mid-operation → serial outputs and word_borrow go 0 immediately, with no clk edge needed; combinational outputs are unaffected.
- WORD_LEN=8, serial 0x35 − 0x12, LSB first, sow on bit 0, BorrowIn=0 → ser_diff bits form 0x23; eow on the 8th bit; word_borrow=0.
- Serial 0x12 − 0x35 → ser_diff bits form 0xDD; word_borrow=1.
- in_valid gaps mid-word → ser_valid drops during gaps; final result is identical to the gap-free case.
- sow re-asserted at bit 4 → no eow for the aborted word; the new word completes 8 valid bits later.
